wb_sdram_bridge: RTL and testbench

Parametrised Wishbone-slave front end for sdram_controller; replaces the ad-hoc valid/ack glue in the user project wrapper. Adds a posted-write buffer so CPU stores retire without waiting on the controller. Enforces read-after-write ordering and owns the controller request port through a single issue FSM. Sits between the WB MI A slave port and sdram_controller (user_addr/rw/data_in/busy/in_valid/out_valid).

---
 rtl/wb_sdram_pkg.sv | 23 ++
 rtl/wb_sdram_bridge_wbuf_fifo.sv | 53 +++++
 rtl/wb_sdram_bridge.sv | 190 +++++++++++++++++++
 tb/tb_wb_sdram_bridge.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_sdram_pkg.sv
// Shared types and defaults for the Wishbone-to-SDRAM-controller bridge.
// Issue FSM encoding, FIFO entry width helper and default parameter values.
package wb_sdram_pkg;

  localparam int DEF_DW             = 32;
  localparam int DEF_AW             = 23;
  localparam int DEF_WBUF_DEPTH     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_RD_ACK  = 3'd4
  } state_e;

  // A posted write is stored as {address, data, byte selects}.
  function automatic int entry_width(input int aw, input int dw);
    return aw + dw + dw / 8;
  endfunction

endpackage

// File: rtl/wb_sdram_bridge_wbuf_fifo.sv
// Posted-write FIFO: synchronous, power-of-2 depth, async active-high reset.
// Push is ignored when full and pop when empty; storage itself is not reset.
module wbuf_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_L = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == DEPTH_L);
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/wb_sdram_bridge.sv
// Wishbone slave front end for sdram_controller with posted writes and an issue FSM.
// Optional read watchdog enabled by defining WB_TIMEOUT_EN.
module wb_sdram_bridge
  import wb_sdram_pkg::*;
#(
  parameter int DW             = DEF_DW,
  parameter int AW             = DEF_AW,
  parameter int WBUF_DEPTH     = DEF_WBUF_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          wbs_stb_i,
  input  logic                          wbs_cyc_i,
  input  logic                          wbs_we_i,
  input  logic [DW/8-1:0]               wbs_sel_i,
  input  logic [DW-1:0]                 wbs_dat_i,
  input  logic [31:0]                   wbs_adr_i,
  output logic                          wbs_ack_o,
  output logic [DW-1:0]                 wbs_dat_o,
  output logic [AW-1:0]                 ctrl_addr,
  output logic                          ctrl_rw,
  output logic [DW-1:0]                 ctrl_data_in,
  output logic [DW/8-1:0]               ctrl_mask,
  output logic                          ctrl_in_valid,
  input  logic                          ctrl_busy,
  input  logic [DW-1:0]                 ctrl_data_out,
  input  logic                          ctrl_out_valid,
  output logic [$clog2(WBUF_DEPTH):0]   wbuf_level,
  output logic                          err_o,
  output state_e                        dbg_state_o
);

  localparam int SW = DW / 8;
  localparam int EW = entry_width(AW, DW);

  state_e         state_q, state_d;
  logic           wr_ack_q, wr_ack_d;
  logic           rd_drop_q, rd_drop_d;
  logic [AW-1:0]  rd_adr_q, rd_adr_d;
  logic [DW-1:0]  dat_q, dat_d;

  logic           req, rd_req, push, pop, fifo_full, fifo_empty;
  logic           timeout, stale;
  logic [EW-1:0]  push_entry, head;
  logic [AW-1:0]  head_adr;
  logic [DW-1:0]  head_dat;
  logic [SW-1:0]  head_sel;
  logic [31-AW:0] unused_adr;

  assign unused_adr = wbs_adr_i[31:AW];
  assign req        = wbs_stb_i & wbs_cyc_i;
  assign rd_req     = req & ~wbs_we_i;
  assign push       = req & wbs_we_i & ~wbs_ack_o & ~fifo_full;
  assign push_entry = {wbs_adr_i[AW-1:0], wbs_dat_i, wbs_sel_i};
  assign {head_adr, head_dat, head_sel} = head;
  // Controller handshake: a request transfers on a cycle with ctrl_in_valid & ~ctrl_busy;
  // address/rw/data/mask are held constant for as long as ctrl_in_valid stays high.
  assign pop        = (state_q == S_WR) & ~ctrl_busy;

  wbuf_fifo #(
    .WIDTH (EW),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (push),
    .din_i   (push_entry),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (wbuf_level)
  );

`ifdef WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          stale_q, stale_d, err_q, err_d;

  // Real data arriving on the last wait cycle wins over the watchdog.
  assign timeout = (state_q == S_RD_WAIT) & (to_cnt_q == TO_LAST)
                 & ~(ctrl_out_valid & ~stale_q);
  assign stale   = stale_q;
  assign err_o   = err_q;

  always_comb begin
    to_cnt_d = (state_q == S_RD_WAIT) ? to_cnt_q + 1'b1 : '0;
    stale_d  = stale_q;
    err_d    = err_q;
    if (ctrl_out_valid) stale_d = 1'b0;
    if (timeout) begin
      stale_d = 1'b1;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      to_cnt_q <= '0;
      stale_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      stale_q  <= stale_d;
      err_q    <= err_d;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
  assign stale   = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    wr_ack_d      = push;
    rd_drop_d     = rd_drop_q;
    rd_adr_d      = rd_adr_q;
    dat_d         = dat_q;
    ctrl_in_valid = 1'b0;
    ctrl_rw       = 1'b0;
    ctrl_addr     = '0;
    ctrl_data_in  = '0;
    ctrl_mask     = '0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_WR;
        end else if (rd_req && !wbs_ack_o) begin
          state_d   = S_RD_REQ;
          rd_adr_d  = wbs_adr_i[AW-1:0];
          rd_drop_d = 1'b0;
        end
      end
      S_WR: begin
        ctrl_in_valid = 1'b1;
        ctrl_rw       = 1'b1;
        ctrl_addr     = head_adr;
        ctrl_data_in  = head_dat;
        ctrl_mask     = head_sel;
        if (!ctrl_busy) state_d = S_IDLE;
      end
      S_RD_REQ: begin
        // Valid follows the live request so an abandoned read can never be accepted.
        ctrl_in_valid = rd_req;
        ctrl_addr     = rd_adr_q;
        if (!rd_req)         state_d = S_IDLE;
        else if (!ctrl_busy) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (!rd_req) rd_drop_d = 1'b1;
        if (ctrl_out_valid && !stale) begin
          dat_d   = ctrl_data_out;
          state_d = S_RD_ACK;
        end else if (timeout) begin
          dat_d   = '1;
          state_d = S_RD_ACK;
        end
      end
      S_RD_ACK: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      wr_ack_q  <= 1'b0;
      rd_drop_q <= 1'b0;
      rd_adr_q  <= '0;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_ack_q  <= wr_ack_d;
      rd_drop_q <= rd_drop_d;
      rd_adr_q  <= rd_adr_d;
      dat_q     <= dat_d;
    end
  end

  assign wbs_ack_o   = wr_ack_q | ((state_q == S_RD_ACK) & ~rd_drop_q);
  assign wbs_dat_o   = dat_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_sdram_bridge.sv
// Bench for wb_sdram_bridge: directed scenarios plus random traffic against a
// memory-level reference model and an ordered queue of expected controller writes.
module tb_wb_sdram_bridge;
  import wb_sdram_pkg::*;

  logic              clk, rst;
  logic              stb, cyc, we;
  logic [3:0]        sel;
  logic [31:0]       dat, adr;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic [22:0]       ctrl_addr;
  logic              ctrl_rw, ctrl_in_valid, ctrl_busy, ctrl_out_valid;
  logic [31:0]       ctrl_data_in, ctrl_data_out;
  logic [3:0]        ctrl_mask;
  logic [2:0]        wbuf_level;
  logic              err_o;
  state_e            dbg_state;

  int vec_cnt = 0, err_cnt = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_sdram_bridge #(.DW(32), .AW(23), .WBUF_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(dat), .wbs_adr_i(adr), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .ctrl_addr(ctrl_addr), .ctrl_rw(ctrl_rw), .ctrl_data_in(ctrl_data_in),
    .ctrl_mask(ctrl_mask), .ctrl_in_valid(ctrl_in_valid), .ctrl_busy(ctrl_busy),
    .ctrl_data_out(ctrl_data_out), .ctrl_out_valid(ctrl_out_valid),
    .wbuf_level(wbuf_level), .err_o(err_o), .dbg_state_o(dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference model: memory as seen by the WB master, and by the controller
  logic [58:0] exp_q[$];
  logic [31:0] gold[int];
  logic [31:0] ctrl_mem[int];
  logic [22:0] exp_rd_addr = '0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] gold_rd(input int k);
    return gold.exists(k) ? gold[k] : 32'h0;
  endfunction

  function automatic logic [31:0] mem_rd(input int k);
    return ctrl_mem.exists(k) ? ctrl_mem[k] : 32'h0;
  endfunction

  // controller model: busy, read latency (0 = never answer), optional stale pulse
  logic        busy_force = 1'b0, busy_rand = 1'b0, inject_stale = 1'b0;
  int          rd_lat = 2, rd_cnt = 0, stale_cnt = 0;
  int          rd_issued = 0, wr_issued = 0;
  logic [31:0] rd_data = '0;
  logic [58:0] e;

  always begin
    @(negedge clk); #1;
    ctrl_out_valid = 1'b0;
    ctrl_busy = busy_force | (busy_rand && ($urandom_range(0, 3) == 0));
    if (stale_cnt > 0) begin
      stale_cnt--;
      if (stale_cnt == 0) begin ctrl_out_valid = 1'b1; ctrl_data_out = 32'hDEAD_BEEF; end
    end
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin ctrl_out_valid = 1'b1; ctrl_data_out = rd_data; end
    end
    if (!rst && ctrl_in_valid && !ctrl_busy) begin
      if (ctrl_rw) begin
        check("wr_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_issue", {ctrl_addr, ctrl_data_in, ctrl_mask}, e);
        end
        ctrl_mem[int'(ctrl_addr)] = merge(mem_rd(int'(ctrl_addr)), ctrl_data_in, ctrl_mask);
        wr_issued++;
      end else begin
        check("rd_after_wr", exp_q.size(), 0);
        check("rd_mask", ctrl_mask, 0);
        check("rd_addr", ctrl_addr, exp_rd_addr);
        rd_data = mem_rd(int'(ctrl_addr));
        rd_cnt  = rd_lat;
        stale_cnt = inject_stale ? 1 : 0;
        inject_stale = 1'b0;
        rd_issued++;
      end
    end
  end

  // ack monitor
  int   ack_total = 0, ack_b2b = 0;
  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    if (wbs_ack_o && prev_ack) ack_b2b++;
    if (wbs_ack_o) ack_total++;
    prev_ack = wbs_ack_o;
  end

  // driver tasks
  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int lat);
    bit got;
    got = 1'b0; lat = 0;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = a; dat = d; sel = s;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk); lat++;
      if (wbs_ack_o) got = 1'b1;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    check("wr_ack_seen", got, 1);
    if (got) begin
      exp_q.push_back({a[22:0], d, s});
      gold[int'(a[22:0])] = merge(gold_rd(int'(a[22:0])), d, s);
    end
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output int lat);
    bit got;
    got = 1'b0; lat = 0;
    exp_rd_addr = a[22:0];
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk); lat++;
      if (wbs_ack_o) got = 1'b1;
    end
    d = wbs_dat_o;
    stb = 1'b0; cyc = 1'b0;
    check("rd_ack_seen", got, 1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && wbuf_level == 0 && dbg_state == S_IDLE) done = 1'b1;
    end
    check("drain_done", done, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, a0, r0, w0;
    logic [31:0] d, a;
    rst = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = '0; dat = '0; adr = '0;
    ctrl_busy = 1'b0; ctrl_out_valid = 1'b0; ctrl_data_out = '0;
    #1 rst = 1'b1;
    #3;
    check("rst_ack", wbs_ack_o, 0);
    check("rst_valid", ctrl_in_valid, 0);
    check("rst_level", wbuf_level, 0);
    check("rst_dat", wbs_dat_o, 0);
    check("rst_err", err_o, 0);
    check("rst_state", dbg_state, S_IDLE);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // single write, controller idle
    wb_write(32'h10, 32'hA5A5_0001, 4'hF, lat);
    check("w1_lat", lat, 1);
    @(negedge clk);
    check("w1_valid", ctrl_in_valid, 1);
    check("w1_rw", ctrl_rw, 1);
    check("w1_mask", ctrl_mask, 4'hF);
    check("w1_addr", ctrl_addr, 23'h10);
    repeat (2) @(negedge clk);
    check("w1_level0", wbuf_level, 0);

    // six writes against a busy controller
    busy_force = 1'b1;
    fork begin repeat (20) @(negedge clk); busy_force = 1'b0; end join_none
    for (int i = 0; i < 4; i++) begin
      wb_write(32'h200 + 32'(4 * i), $urandom, 4'hF, lat);
      check("full_wr_lat", lat, 1);
    end
    check("full_level", wbuf_level, 4);
    wb_write(32'h210, $urandom, 4'h3, lat);
    check("wr5_held", lat > 8, 1);
    wb_write(32'h214, $urandom, 4'hC, lat);
    drain();

    // read-after-write ordering
    rd_lat = 3;
    a0 = ack_total; r0 = rd_issued;
    wb_write(32'h40, 32'h1234_5678, 4'hF, lat);
    wb_read(32'h40, d, lat);
    check("raw_data", d, 32'h1234_5678);
    repeat (3) @(negedge clk);
    check("raw_acks", ack_total - a0, 2);
    check("raw_one_rd", rd_issued - r0, 1);

    // master abandons a read while the controller is busy
    busy_force = 1'b1;
    a0 = ack_total; r0 = rd_issued;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h44;
    repeat (3) @(negedge clk);
    check("drop_in_rdreq", dbg_state, S_RD_REQ);
    cyc = 1'b0;
    repeat (2) @(negedge clk);
    stb = 1'b0;
    check("drop_idle", dbg_state, S_IDLE);
    busy_force = 1'b0;
    repeat (5) @(negedge clk);
    check("drop_no_rd", rd_issued - r0, 0);
    check("drop_no_ack", ack_total - a0, 0);

    // random traffic
    busy_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      a = 32'h100 + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        wb_write(a, $urandom, 4'($urandom_range(1, 15)), lat);
      end else begin
        rd_lat = $urandom_range(1, 4);
        wb_read(a, d, lat);
        check("rand_rd", d, gold_rd(int'(a[22:0])));
      end
    end
    busy_rand = 1'b0;
    drain();

    // async reset during an outstanding read with posted writes queued
    rd_lat = 0;
    r0 = rd_issued;
    exp_rd_addr = 23'h80;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h80; sel = 4'hF;
    for (int i = 0; i < 50 && rd_issued == r0; i++) @(negedge clk);
    check("rst_rd_issued", rd_issued - r0, 1);
    stb = 1'b0; cyc = 1'b0;
    wb_write(32'h84, 32'h0BAD_0001, 4'hF, lat);
    wb_write(32'h88, 32'h0BAD_0002, 4'hF, lat);
    check("rst_lvl2", wbuf_level, 2);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_ack", wbs_ack_o, 0);
    check("arst_valid", ctrl_in_valid, 0);
    check("arst_addr", ctrl_addr, 0);
    check("arst_rw", ctrl_rw, 0);
    check("arst_mask", ctrl_mask, 0);
    check("arst_wdata", ctrl_data_in, 0);
    check("arst_dat", wbs_dat_o, 0);
    check("arst_level", wbuf_level, 0);
    check("arst_state", dbg_state, S_IDLE);
    exp_q.delete();
    gold = ctrl_mem;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    a0 = ack_total; r0 = rd_issued; w0 = wr_issued;
    repeat (10) @(negedge clk);
    check("post_rst_no_ack", ack_total - a0, 0);
    check("post_rst_no_req", (rd_issued - r0) + (wr_issued - w0), 0);

`ifdef WB_TIMEOUT_EN
    // read watchdog with a late response
    wb_write(32'h100, 32'hCAFE_0123, 4'hF, lat);
    drain();
    rd_lat = 0;
    wb_read(32'h100, d, lat);
    check("to_lat", lat, 10);
    check("to_data", d, 32'hFFFF_FFFF);
    check("to_err", err_o, 1);
    rd_lat = 3;
    inject_stale = 1'b1;
    wb_read(32'h100, d, lat);
    check("post_to_data", d, gold_rd(32'h100));
    check("err_sticky", err_o, 1);
`else
    check("err_tied", err_o, 0);
`endif

    check("ack_never_b2b", ack_b2b, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
